regfile_scan_reader: RTL and testbench

- Read-side counterpart to the Fibonacci sequencer, which writes a sequence into the 16-entry register file.
- This block walks the register file's A read port from r0 to r15 and latches each value onto the board display.
- Each value is held for a configurable dwell time, or until the user presses Step.
- It also checks the stored contents against the Fibonacci recurrence and raises a sticky error flag with the index of the first failing register.

---
 rtl/regfile_scan_reader.sv | 137 +++++++++++++
 tb/tb_regfile_scan_reader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scan_reader.sv
// Scans the register file A port from r0 to r(NUM_REGS-1) and latches each
// value onto the display. Each value is held for DWELL_COUNT cycles or until
// Step is pressed. The stored values are checked against the Fibonacci
// recurrence, and the first failing index is latched as a sticky error.
module regfile_scan_reader #(
    parameter int unsigned DWELL_COUNT  = 30000000,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned NUM_REGS     = 16
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Step,
    input  logic [15:0] ReadData,
    output logic [3:0]  ReadSelect,
    output logic [15:0] DisplayValue,
    output logic [3:0]  DisplayIndex,
    output logic        Busy,
    output logic        Done,
    output logic        Error,
    output logic [3:0]  ErrorIndex
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned DW_W   = $clog2(DWELL_COUNT + 1);
    localparam int unsigned WT_W   = $clog2(READ_LATENCY + 1);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REGS - 1);
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_COUNT - 1);
    localparam logic [WT_W-1:0]  WAIT_LAST  = WT_W'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CAPTURE,
        DWELL
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [WT_W-1:0]    wait_cnt;
    logic [DW_W-1:0]    dwell_cnt;
    logic [DATA_W-1:0]  prev1;
    logic [DATA_W-1:0]  prev2;
    logic               start_q;
    logic               step_q;

    logic               start_edge_c;
    logic               step_edge_c;
    logic [DATA_W-1:0]  fib_sum_c;
    logic               dwell_exit_c;

    // Falling-edge detect on the active-low buttons and the expected next term
    assign start_edge_c = start_q & ~Start;
    assign step_edge_c  = step_q & ~Step;
    assign fib_sum_c    = DATA_W'(prev1 + prev2);
    assign dwell_exit_c = (dwell_cnt == DWELL_LAST) || step_edge_c;

    // Scan sequencer: select, wait for read data, capture and check, then dwell
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state        <= IDLE;
            idx          <= '0;
            wait_cnt     <= '0;
            dwell_cnt    <= '0;
            prev1        <= '0;
            prev2        <= '0;
            start_q      <= 1'b1;
            step_q       <= 1'b1;
            ReadSelect   <= '0;
            DisplayValue <= '0;
            DisplayIndex <= '0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            Error        <= 1'b0;
            ErrorIndex   <= '0;
        end else begin
            start_q <= Start;
            step_q  <= Step;
            case (state)
                IDLE: begin
                    if (start_edge_c) begin
                        idx        <= '0;
                        ReadSelect <= '0;
                        Busy       <= 1'b1;
                        Done       <= 1'b0;
                        Error      <= 1'b0;
                        ErrorIndex <= '0;
                        wait_cnt   <= '0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= '0;
                        state    <= CAPTURE;
                    end else begin
                        wait_cnt <= WT_W'(wait_cnt + WT_W'(1));
                    end
                end
                CAPTURE: begin
                    DisplayValue <= ReadData;
                    DisplayIndex <= idx;
                    // Only the first mismatch of a scan is recorded
                    if ((idx >= IDX_W'(2)) && (ReadData != fib_sum_c) && !Error) begin
                        Error      <= 1'b1;
                        ErrorIndex <= idx;
                    end
                    prev2     <= prev1;
                    prev1     <= ReadData;
                    dwell_cnt <= '0;
                    state     <= DWELL;
                end
                DWELL: begin
                    if (dwell_exit_c) begin
                        dwell_cnt <= '0;
                        if (idx == LAST_IDX) begin
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            idx        <= IDX_W'(idx + IDX_W'(1));
                            ReadSelect <= IDX_W'(idx + IDX_W'(1));
                            wait_cnt   <= '0;
                            state      <= WAIT;
                        end
                    end else begin
                        dwell_cnt <= DW_W'(dwell_cnt + DW_W'(1));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_scan_reader.sv
// Directed bench for regfile_scan_reader with DWELL_COUNT=4, READ_LATENCY=1.
// Edge 0 is the clock edge that samples the Start falling edge. Capture of
// index i lands on edge 6*i+2, and Done rises on edge 96.
module tb_regfile_scan_reader;

    localparam int unsigned DWELL = 4;
    localparam int unsigned RLAT  = 1;
    localparam int unsigned NREG  = 16;
    localparam int unsigned PER   = RLAT + 1 + DWELL;
    localparam int unsigned LAST  = NREG * PER;

    localparam logic [15:0] FIB [16] = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8,
        16'd13, 16'd21, 16'd34, 16'd55, 16'd89, 16'd144, 16'd233, 16'd377, 16'd610, 16'd987};
    localparam logic [15:0] WRAP [16] = '{16'hFFFF, 16'd2, 16'd1, 16'd3, 16'd4, 16'd7,
        16'd11, 16'd18, 16'd29, 16'd47, 16'd76, 16'd123, 16'd199, 16'd322, 16'd521, 16'd843};

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        step;
    logic [15:0] read_data;
    logic [3:0]  read_select;
    logic [15:0] display_value;
    logic [3:0]  display_index;
    logic        busy;
    logic        done;
    logic        error;
    logic [3:0]  error_index;

    logic [15:0] mem [16];
    int          n_checks;
    int          n_pass;

    regfile_scan_reader #(
        .DWELL_COUNT (DWELL),
        .READ_LATENCY(RLAT),
        .NUM_REGS    (NREG)
    ) dut (
        .Clock       (clk),
        .Reset       (rst_n),
        .Start       (start),
        .Step        (step),
        .ReadData    (read_data),
        .ReadSelect  (read_select),
        .DisplayValue(display_value),
        .DisplayIndex(display_index),
        .Busy        (busy),
        .Done        (done),
        .Error       (error),
        .ErrorIndex  (error_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file with a one-cycle read
    always @(posedge clk) read_data <= mem[read_select];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] tbl [16]);
        for (int i = 0; i < 16; i++) mem[i] = tbl[i];
    endtask

    // Drive a Start press (optionally with Step) so that edge 0 samples it
    task automatic press_start(input logic with_step);
        start = 1'b0;
        if (with_step) step = 1'b0;
        tick();
        start = 1'b1;
        step  = 1'b1;
    endtask

    // Run edges 1..LAST of an undisturbed scan and check every capture
    task automatic run_scan(input logic exp_err, input int exp_idx, input logic [15:0] tbl [16]);
        for (int k = 1; k <= int'(LAST); k++) begin
            tick();
            if (k % int'(PER) == 2) begin
                int i;
                i = (k - 2) / int'(PER);
                check($sformatf("value[%0d]", i), 32'(display_value), 32'(tbl[i]));
                check($sformatf("index[%0d]", i), 32'(display_index), 32'(i));
                check($sformatf("err_at[%0d]", i), 32'(error), 32'(exp_err && (i >= exp_idx)));
            end
            if (k == int'(LAST) - 1) check("done_early", 32'(done), 32'd0);
        end
        check("done", 32'(done), 32'd1);
        check("busy_end", 32'(busy), 32'd0);
        check("error_end", 32'(error), 32'(exp_err));
        check("error_idx_end", 32'(error_index), exp_err ? 32'(exp_idx) : 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sel"},  32'(read_select),   32'd0);
        check({tag, "_val"},  32'(display_value), 32'd0);
        check({tag, "_idx"},  32'(display_index), 32'd0);
        check({tag, "_busy"}, 32'(busy),          32'd0);
        check({tag, "_done"}, 32'(done),          32'd0);
        check({tag, "_err"},  32'(error),         32'd0);
        check({tag, "_eidx"}, 32'(error_index),   32'd0);
    endtask

    initial begin
        logic [15:0] bad [16];
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        start    = 1'b1;
        step     = 1'b1;
        load(FIB);
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Clean Fibonacci scan
        press_start(1'b0);
        check("start_busy", 32'(busy), 32'd1);
        run_scan(1'b0, 0, FIB);

        // Corrupted r7; r8 also mismatches but the first index must stick
        bad = FIB;
        bad[7] = 16'h0014;
        load(bad);
        press_start(1'b0);
        check("restart_done_clr", 32'(done), 32'd0);
        run_scan(1'b1, 7, bad);

        // New Start after Done clears Done and Error; clean rescan
        load(FIB);
        press_start(1'b0);
        check("rescan_done_clr", 32'(done), 32'd0);
        check("rescan_err_clr", 32'(error), 32'd0);
        check("rescan_eidx_clr", 32'(error_index), 32'd0);
        run_scan(1'b0, 0, FIB);

        // Wrap-around values with Start and Step pressed together in IDLE
        load(WRAP);
        press_start(1'b1);
        run_scan(1'b0, 0, WRAP);
        load(FIB);

        // Step one cycle into the dwell of r3 (capture at edge 20)
        press_start(1'b0);
        repeat (21) tick();
        step = 1'b0;
        tick();
        step = 1'b1;
        tick();
        check("step_idx_hold", 32'(display_index), 32'd3);
        tick();
        check("step_idx_adv", 32'(display_index), 32'd4);
        check("step_val_adv", 32'(display_value), 32'(FIB[4]));
        begin
            int budget;
            budget = 200;
            while (!done && budget > 0) begin
                tick();
                budget--;
            end
            check("step_done_timeout", 32'(done), 32'd1);
        end

        // Start pressed during the dwell of r2 is ignored
        press_start(1'b0);
        repeat (15) tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        repeat (4) tick();
        check("guard_idx", 32'(display_index), 32'd3);
        check("guard_val", 32'(display_value), 32'(FIB[3]));
        repeat (int'(LAST) - 21) tick();
        check("guard_done_early", 32'(done), 32'd0);
        tick();
        check("guard_done", 32'(done), 32'd1);

        // Reset during the dwell of r5 (capture at edge 32)
        press_start(1'b0);
        repeat (34) tick();
        check("pre_rst_idx", 32'(display_index), 32'd5);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_sel", 32'(read_select), 32'd0);
        press_start(1'b0);
        tick();
        tick();
        check("post_rst_idx", 32'(display_index), 32'd0);
        check("post_rst_val", 32'(display_value), 32'(FIB[0]));
        check("post_rst_busy2", 32'(busy), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
